// File: rtl/score_digit_renderer.sv
// Score renderer: binary score -> BCD (shift-and-add-3) -> display register -> 2-stage glyph pixel pipeline.
// Optional leading-zero blanking is enabled by defining SCORE_LEADING_ZERO_BLANK_EN.
module score_digit_renderer #(
  parameter int DIGITS     = 4,
  parameter int BIN_W      = 14,
  parameter int SCALE_LOG2 = 1,
  parameter int X0         = 16,
  parameter int Y0         = 16,
  parameter int COORD_W    = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BIN_W-1:0]   score_in,
  input  logic               score_load,
  output logic               busy,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  output logic               pix_on
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic int unsigned pow10(input int n);
    int unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int unsigned MAX_VAL = pow10(DIGITS) - 1;
  localparam int unsigned FIELD_W = DIGITS * (8 << SCALE_LOG2);
  localparam int unsigned FIELD_H = 16 << SCALE_LOG2;

  // Rows 0-9 of glyphs '0'..'9'; bit 7 is the leftmost pixel.
  localparam logic [7:0] FONT [0:99] = '{
    8'h3C, 8'h66, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C,
    8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E,
    8'h3C, 8'h66, 8'h06, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'h60, 8'h7E,
    8'h3C, 8'h66, 8'h06, 8'h06, 8'h1C, 8'h06, 8'h06, 8'h06, 8'h66, 8'h3C,
    8'h0C, 8'h1C, 8'h2C, 8'h4C, 8'h4C, 8'h7E, 8'h0C, 8'h0C, 8'h0C, 8'h0C,
    8'h7E, 8'h60, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h06, 8'h06, 8'h66, 8'h3C,
    8'h3C, 8'h66, 8'h60, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C,
    8'h7E, 8'h06, 8'h06, 8'h0C, 8'h0C, 8'h18, 8'h18, 8'h30, 8'h30, 8'h30,
    8'h3C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C,
    8'h3C, 8'h66, 8'h66, 8'h66, 8'h7E, 8'h06, 8'h06, 8'h06, 8'h66, 8'h3C
  };

  function automatic logic [7:0] glyph(input logic [3:0] code, input logic [3:0] row);
    if (code < 4'd10 && row < 4'd10) return FONT[int'(code) * 10 + int'(row)];
    return 8'h00;
  endfunction

  function automatic logic [BIN_W-1:0] sat(input logic [BIN_W-1:0] v);
    if (32'(v) > MAX_VAL) return MAX_VAL[BIN_W-1:0];
    return v;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_COMMIT} state_t;

  state_t             r_state;
  logic [BIN_W-1:0]   r_shift;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic [BCD_W-1:0]   r_disp;
  logic [DIGITS-1:0]  r_blank;
  logic               r_pend;
  logic [BIN_W-1:0]   r_pend_val;
  logic [BCD_W-1:0]   w_adj;
  logic [DIGITS-1:0]  w_blank_nxt;

  assign busy = (r_state != S_IDLE);

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++)
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
  end

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  // Reset shows "0", matching what a committed zero score would render.
  localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1) << (DIGITS - 1));
  logic w_seen;
  always_comb begin
    w_seen      = 1'b0;
    w_blank_nxt = '0;
    for (int i = 0; i < DIGITS - 1; i++) begin
      if (r_bcd[4*(DIGITS-1-i) +: 4] != 4'd0) w_seen = 1'b1;
      w_blank_nxt[i] = ~w_seen;
    end
  end
`else
  localparam logic [DIGITS-1:0] BLANK_RST = '0;
  assign w_blank_nxt = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_disp     <= '0;
      r_blank    <= BLANK_RST;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (score_load) begin
            r_shift <= sat(score_in);
            r_bcd   <= '0;
            r_cnt   <= CNT_W'(BIN_W);
            r_state <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          {r_bcd, r_shift} <= {w_adj, r_shift} << 1;
          r_cnt            <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) r_state <= S_COMMIT;
          if (score_load) begin
            r_pend     <= 1'b1;
            r_pend_val <= sat(score_in);
          end
        end
        S_COMMIT: begin
          r_disp  <= r_bcd;
          r_blank <= w_blank_nxt;
          // A load arriving in this very cycle is newer than any pending one.
          if (r_pend || score_load) begin
            r_shift <= score_load ? sat(score_in) : r_pend_val;
            r_bcd   <= '0;
            r_cnt   <= CNT_W'(BIN_W);
            r_pend  <= 1'b0;
            r_state <= S_CONVERT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic [COORD_W:0]   w_dx, w_dy;
  logic [COORD_W-1:0] w_rx, w_ry, w_idx;
  logic               w_in, w_blk;
  logic [3:0]         w_code;

  assign w_dx  = {1'b0, pixel_x} - (COORD_W+1)'(X0);
  assign w_dy  = {1'b0, pixel_y} - (COORD_W+1)'(Y0);
  assign w_rx  = w_dx[COORD_W-1:0];
  assign w_ry  = w_dy[COORD_W-1:0];
  assign w_idx = w_rx >> (3 + SCALE_LOG2);
  assign w_in  = ~w_dx[COORD_W] & ~w_dy[COORD_W] &
                 (32'(w_rx) < FIELD_W) & (32'(w_ry) < FIELD_H);

  always_comb begin
    w_code = 4'd0;
    w_blk  = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (w_idx == COORD_W'(i)) begin
        w_code = r_disp[4*(DIGITS-1-i) +: 4];
        w_blk  = r_blank[i];
      end
  end

  logic [3:0] r_code, r_row;
  logic [2:0] r_col;
  logic       r_in, r_blk;
  logic [7:0] w_font;

  assign w_font = glyph(r_code, r_row);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_code <= '0;
      r_row  <= '0;
      r_col  <= '0;
      r_in   <= 1'b0;
      r_blk  <= 1'b0;
      pix_on <= 1'b0;
    end else begin
      r_code <= w_code;
      r_row  <= 4'(w_ry >> SCALE_LOG2);
      r_col  <= 3'(w_rx >> SCALE_LOG2);
      r_in   <= w_in;
      r_blk  <= w_blk;
      pix_on <= r_in & ~r_blk & w_font[3'd7 - r_col];
    end
  end

endmodule

// File: tb/tb_score_digit_renderer.sv
// Self-checking bench for score_digit_renderer (default parameters); honours SCORE_LEADING_ZERO_BLANK_EN.
module tb_score_digit_renderer;

  localparam int X0 = 16;
  localparam int Y0 = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] score_in = '0;
  logic        score_load = 1'b0;
  logic        busy;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic        pix_on;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  score_digit_renderer dut (
    .clk(clk), .rst(rst), .score_in(score_in), .score_load(score_load), .busy(busy),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pix_on(pix_on)
  );

  logic [7:0] font_tb [10][10] = '{
    '{8'h3C, 8'h66, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C},
    '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E},
    '{8'h3C, 8'h66, 8'h06, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'h60, 8'h7E},
    '{8'h3C, 8'h66, 8'h06, 8'h06, 8'h1C, 8'h06, 8'h06, 8'h06, 8'h66, 8'h3C},
    '{8'h0C, 8'h1C, 8'h2C, 8'h4C, 8'h4C, 8'h7E, 8'h0C, 8'h0C, 8'h0C, 8'h0C},
    '{8'h7E, 8'h60, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h06, 8'h06, 8'h66, 8'h3C},
    '{8'h3C, 8'h66, 8'h60, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C},
    '{8'h7E, 8'h06, 8'h06, 8'h0C, 8'h0C, 8'h18, 8'h18, 8'h30, 8'h30, 8'h30},
    '{8'h3C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C},
    '{8'h3C, 8'h66, 8'h66, 8'h66, 8'h7E, 8'h06, 8'h06, 8'h06, 8'h66, 8'h3C}
  };

  // Reference: 4-digit decimal field, 16x32 px cells (2x magnified 8x16 glyphs).
  function automatic logic exp_pix(input int score, input int x, input int y);
    int v, rx, ry, d, col, row, p, dig;
    logic [7:0] fr;
    v = (score > 9999) ? 9999 : score;
    if (x < X0 || y < Y0) return 1'b0;
    rx = x - X0;
    ry = y - Y0;
    if (rx >= 64 || ry >= 32) return 1'b0;
    d   = rx / 16;
    col = (rx / 2) % 8;
    row = ry / 2;
    if (row >= 10) return 1'b0;
    p = 1;
    for (int i = 0; i < 3 - d; i++) p = p * 10;
    dig = (v / p) % 10;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    if (d < 3 && v < p) return 1'b0;
`endif
    fr = font_tb[dig][row];
    return fr[7 - col];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Called at a negedge; returns the number of cycles busy was seen high.
  task automatic load_and_wait(input int v, output int cycles);
    score_in   = 14'(v);
    score_load = 1'b1;
    @(negedge clk);
    score_load = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic probe(input string name, input int x, input int y, input logic exp);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    repeat (2) @(negedge clk);
    check(name, 32'(pix_on), 32'(exp));
  endtask

  typedef struct {
    string name;
    int    score;
    int    x;
    int    y;
    logic  exp;
  } vec_t;

  vec_t tbl[12];
  int   cyc, hi, cur, cnt, lat;
  logic fell;
  logic q[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{"one_r0_c3",      1234, X0+6,  Y0,    1'b1};
    tbl[1]  = '{"one_r0_c0",      1234, X0,    Y0,    1'b0};
    tbl[2]  = '{"two_r0_c3",      1234, X0+22, Y0,    1'b1};
    tbl[3]  = '{"three_r0_c1",    1234, X0+34, Y0,    1'b0};
    tbl[4]  = '{"y_above",        1234, X0+6,  Y0-1,  1'b0};
    tbl[5]  = '{"sat_nine_r4_c3", 16383, X0+6, Y0+8,  1'b1};
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    tbl[6]  = '{"lead_zero",      7,    X0+6,  Y0,    1'b0};
`else
    tbl[6]  = '{"lead_zero",      7,    X0+6,  Y0,    1'b1};
`endif
    tbl[7]  = '{"seven_r0_c3",    7,    X0+54, Y0,    1'b1};
    tbl[8]  = '{"x_left",         7,    X0-1,  Y0,    1'b0};
    tbl[9]  = '{"x_right",        7,    X0+64, Y0,    1'b0};
    tbl[10] = '{"font_row10",     7,    X0+54, Y0+20, 1'b0};
    tbl[11] = '{"font_row15",     7,    X0+54, Y0+31, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_pix", 32'(pix_on), 0);
    rst = 1'b0;
    @(negedge clk);
    probe("rst_lsd_zero", X0+54, Y0, 1'b1);
    probe("rst_msd", X0+6, Y0, exp_pix(0, X0+6, Y0));

    // Reset in the middle of a conversion
    pixel_x = 10'(X0+54);
    pixel_y = 10'(Y0);
    score_in = 14'd1234;
    score_load = 1'b1;
    @(negedge clk);
    score_load = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_pix", 32'(pix_on), 0);
    @(negedge clk);
    rst = 1'b0;
    probe("abort_disp_zero", X0+54, Y0, 1'b1);
    load_and_wait(1234, cyc);
    check("busy_len_after_abort", cyc, 15);
    probe("lsd_four_c3", X0+54, Y0, 1'b0);
    cur = 1234;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].score != cur) begin
        load_and_wait(tbl[i].score, cyc);
        check({tbl[i].name, "_busy_len"}, cyc, 15);
        cur = tbl[i].score;
      end
      probe(tbl[i].name, tbl[i].x, tbl[i].y, tbl[i].exp);
    end

    // Load while busy: LSD col 1 row 0 is lit for '5' but not for '2'
    pixel_x = 10'(X0+50);
    pixel_y = 10'(Y0);
    score_in = 14'd5;
    score_load = 1'b1;
    hi = 0;
    fell = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) score_load = 1'b0;
      if (k == 2) begin
        score_in = 14'd42;
        score_load = 1'b1;
      end
      if (k == 3) score_load = 1'b0;
      if (busy === 1'b1 && !fell) hi++;
      else fell = 1'b1;
      if (k == 17) check("first_commit_5", 32'(pix_on), 1);
      if (k == 32) check("second_commit_2", 32'(pix_on), 0);
    end
    check("busy_continuous", hi, 30);
    cur = 42;
    probe("tens_four_r3", X0+34, Y0+6, exp_pix(cur, X0+34, Y0+6));
    probe("hundreds_lead", X0+22, Y0, exp_pix(cur, X0+22, Y0));

    // Randomized loads with streamed random pixels against the reference model
    for (int r = 0; r < 8; r++) begin
      case (r)
        0:       cur = $urandom_range(0, 9);
        1:       cur = $urandom_range(10, 999);
        2:       cur = $urandom_range(10000, 16383);
        default: cur = $urandom_range(0, 16383);
      endcase
      load_and_wait(cur, cyc);
      check("rand_busy_len", cyc, 15);
      q.delete();
      cnt = 0;
      lat = 0;
      for (int c = 0; c < 202; c++) begin
        if (q.size() == 2) begin
          check($sformatf("rand_pix s=%0d x=%0d y=%0d", cur, pixel_x, pixel_y), 32'(pix_on), 32'(q.pop_front()));
          cnt++;
        end
        if (c < 200) begin
          pixel_x = 10'($urandom_range(0, X0 + 72));
          pixel_y = 10'($urandom_range(0, Y0 + 36));
          q.push_back(exp_pix(cur, int'(pixel_x), int'(pixel_y)));
        end
        @(negedge clk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/score_digit_renderer.md
# score_digit_renderer

Parametrised multi-digit score renderer for the VGA pixel path. A binary score is loaded through a load/busy handshake and converted to BCD by an iterative shift-and-add-3 state machine. The result is committed atomically to a display register. A 2-stage pipeline maps the current pixel coordinates onto the team's 8×16 digit font and produces a registered `pix_on` for the colour mux.

## Interface
Parameters:
- `DIGITS`, 4: number of decimal digits shown; must be 1–6.
- `BIN_W`, 14: width of the binary score input.
- `SCALE_LOG2`, 1: glyph magnification of 2^SCALE_LOG2. Cell pitch is 8<<SCALE_LOG2 px; cell height is 16<<SCALE_LOG2 px.
- `X0`, 16: left edge of the field, in pixels.
- `Y0`, 16: top edge of the field, in pixels.
- `COORD_W`, 10: width of the pixel coordinates.

Ports:
- `clk` in 1: pixel clock; single clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `score_in` in BIN_W: binary score, sampled on a load.
- `score_load` in 1: single-cycle load request.
- `busy` out 1: high while a conversion is in progress.
- `pixel_x` in COORD_W: current pixel column.
- `pixel_y` in COORD_W: current pixel row.
- `pix_on` out 1: digit pixel lit. Registered; 2-cycle latency from `pixel_x`/`pixel_y`.

## Operation
**Reset values.** `rst` forces:
- state IDLE, `busy`=0, `pix_on`=0;
- display register = all zero digits, pending flag = 0;
- all pipeline registers = 0.

Reset mid-conversion aborts the conversion without writing the display register.

**Converter FSM.** States are IDLE, CONVERT, COMMIT. `busy` = (state != IDLE), decoded from the state register.
- IDLE & `score_load`:
  - Capture min(`score_in`, 10^DIGITS−1) into the shift register.
  - Clear the BCD scratch and set the step count to BIN_W.
  - Go to CONVERT.
- CONVERT: each cycle, add 3 to every scratch nibble ≥5, then shift {scratch, shift} left 1. After BIN_W steps go to COMMIT.
- COMMIT:
  - Display register ← scratch.
  - Recompute the blank mask (see Configuration).
  - If the pending flag is set, reload from the pending value, clear the flag and go to CONVERT. Otherwise go to IDLE.
- `score_load` while `busy`: the pending flag is set and the pending value is overwritten (last load wins, saturated the same way).
- `score_load` in the same cycle as COMMIT counts as pending; it is not lost.

**Render pipeline.**
- S1 (registered):
  - rx = `pixel_x`−X0 and ry = `pixel_y`−Y0, both unsigned, with borrow detection.
  - in_field = no borrow & rx < DIGITS·(8<<SCALE_LOG2) & ry < (16<<SCALE_LOG2).
  - digit index = rx>>(3+SCALE_LOG2). Index 0 is the most significant digit, leftmost.
  - col = (rx>>SCALE_LOG2)&7; row = (ry>>SCALE_LOG2)&15.
  - Register the selected BCD code, row, col, in_field and blank bit.
- S2: font row = glyph(code,row); `pix_on` ← in_field & ~blank & fontrow[7−col].
- Font bits: bit 7 is the leftmost pixel. Rows 10–15 are blank. Codes 10–15 render blank.
- The display register can change mid-frame; there is no tearing within a digit pixel because the code is registered in S1.

## Timing
- Load sampled at edge E0; `busy` rises after E0.
- CONVERT steps run on E1..E_BIN_W; COMMIT runs at E_(BIN_W+1).
- `busy` falls after E_(BIN_W+1); the display is valid from that edge. Busy pulse = BIN_W+1 cycles (15 at default).
- With a pending load, `busy` stays high continuously through the back-to-back conversions.
- Pixel coordinates presented before edge N appear on `pix_on` after edge N+1.

## Configuration
- `SCORE_LEADING_ZERO_BLANK_EN` defined:
  - At COMMIT, blank mask bit i = 1 for every digit more significant than the first nonzero digit.
  - The least significant digit is never blanked, so a score of 0 renders "0".
- Undefined: the blank mask is constant 0 and leading zeros are drawn.

## Test plan
- Reset mid-conversion: load 1234, assert `rst` at cycle 5 → `busy`=0 and `pix_on`=0 immediately; display reads 0000; after a release, a new load converts normally.
- Basic conversion: load 1234 → `busy` high exactly 15 cycles.
  - Pixel (X0+6, Y0), digit '1' row 0 = 00011000, col 3 → `pix_on`=1 two cycles later.
  - Pixel (X0, Y0) → 0.
- Saturation: load 16383 → display 9999; pixel (X0+6, Y0+8), digit '9' row 4 = 01111110, col 3 → 1.
- Load while busy: load 5, then load 42 at cycle 3 → display 0005 at the first COMMIT, then 0042 at the second; `busy` continuous for 30 cycles.
- Blanking: load 7; probe pixel (X0+6, Y0), digit 0 col 3.
  - Macro defined: digits 0–2 → `pix_on`=0 everywhere.
  - Macro undefined: the probed pixel → 1.
- Field bounds: x = X0−1, x = X0+64, y = Y0+20 (font row 10) → `pix_on`=0. y = Y0+31 is still in the field but in a blank row → 0.
